// File: rtl/mash_pkg.sv
// -----------------------------------------------------------------------------
// mash_pkg
// Shared constants and helpers for the multi-stage MASH modulator:
//   MASH_MAX_STAGES  - largest number of first-order stages supported
//   MASH_LFSR_SEED   - reset value of the dither LFSR
//   MASH_LFSR_TAPS   - feedback tap mask (bits 0,2,3,5)
//   mash_min_out_bw  - narrowest signed output able to hold an order-L result
//   mash_lfsr_next   - one Fibonacci shift of the dither LFSR
// -----------------------------------------------------------------------------
package mash_pkg;

    localparam int          MASH_MAX_STAGES = 4;
    localparam logic [15:0] MASH_LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] MASH_LFSR_TAPS  = 16'h002D;

    // Order-L output spans -(2^(L-1)-1) .. 2^(L-1), which needs L+1 signed bits.
    function automatic int mash_min_out_bw(input int order);
        return order + 1;
    endfunction

    // Feedback is the XOR of the tapped bits, shifted in at the top.
    function automatic logic [15:0] mash_lfsr_next(input logic [15:0] state);
        return {^(state & MASH_LFSR_TAPS), state[15:1]};
    endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// -----------------------------------------------------------------------------
// mash_acc_stage
// One first-order MASH accumulator: WIDTH-bit modular add with carry in/out.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the accumulator this cycle
//   clr        : when advancing, load zero instead of the sum
//   cin        : carry-in (dither bit)
//   addend     : value added to the accumulator
//   sum        : combinational acc + addend + cin (mod 2^WIDTH), feeds next stage
//   cout       : overflow of that add
// -----------------------------------------------------------------------------
module mash_acc_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             cin,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] acc_reg;

    assign {cout, sum} = {1'b0, acc_reg} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= clr ? '0 : sum;
        end
    end

endmodule

// File: rtl/axis_mash_nstage.sv
// -----------------------------------------------------------------------------
// axis_mash_nstage
// AXI-Stream MASH sigma-delta modulator with N_STAGES first-order stages and a
// runtime-selectable active order.
//   aclk, arst_n          : clock, asynchronous active-low reset
//   cfg_order             : requested order, clamped to 1..N_STAGES per sample
//   dither_en             : add LFSR bit 0 as carry into the last active stage
//   s_axis_data_*         : signed WIDTH-bit input samples
//   m_axis_data_*         : signed OUT_BW-bit modulator output, latency 1
// -----------------------------------------------------------------------------
module axis_mash_nstage
    import mash_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int N_STAGES = 3,
    parameter int OUT_BW   = 6
) (
    input  logic                     aclk,
    input  logic                     arst_n,
    input  logic [2:0]               cfg_order,
    input  logic                     dither_en,
    input  logic signed [WIDTH-1:0]  s_axis_data_tdata,
    input  logic                     s_axis_data_tvalid,
    output logic                     s_axis_data_tready,
    output logic signed [OUT_BW-1:0] m_axis_data_tdata,
    output logic                     m_axis_data_tvalid,
    input  logic                     m_axis_data_tready
);

    if (N_STAGES < 1 || N_STAGES > MASH_MAX_STAGES) begin : g_bad_stages
        $error("axis_mash_nstage: N_STAGES must be in 1..4");
    end
    if (OUT_BW < mash_min_out_bw(N_STAGES)) begin : g_bad_out_bw
        $error("axis_mash_nstage: OUT_BW too narrow for N_STAGES");
    end

    logic                     accept;
    logic [2:0]               order_eff;
    logic [WIDTH-1:0]         u_offset;
    logic [15:0]              lfsr_reg;
    logic signed [OUT_BW-1:0] m_tdata_reg;
    logic                     m_tvalid_reg;

    assign s_axis_data_tready = !m_tvalid_reg || m_axis_data_tready;
    assign accept             = s_axis_data_tvalid && s_axis_data_tready;
    assign m_axis_data_tdata  = m_tdata_reg;
    assign m_axis_data_tvalid = m_tvalid_reg;

    // Offset binary: flipping the MSB maps x to x + 2^(WIDTH-1).
    assign u_offset = {~s_axis_data_tdata[WIDTH-1], s_axis_data_tdata[WIDTH-2:0]};

    always_comb begin
        order_eff = cfg_order;
        if (cfg_order == 3'd0) begin
            order_eff = 3'd1;
        end else if (cfg_order > 3'(N_STAGES)) begin
            order_eff = 3'(N_STAGES);
        end
    end

    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
        localparam logic [2:0] STAGE_NUM = 3'(gi + 1);

        logic                     active;
        logic                     last;
        logic [WIDTH-1:0]         addend;
        logic [WIDTH-1:0]         sum;
        logic                     carry;
        logic signed [OUT_BW-1:0] carry_s;
        logic signed [OUT_BW-1:0] diff;
        logic signed [OUT_BW-1:0] t_val;

        assign active = (STAGE_NUM <= order_eff);
        assign last   = (STAGE_NUM == order_eff);

        if (gi == 0) begin : g_first
            assign addend = u_offset;
        end else begin : g_chain
            assign addend = g_stage[gi-1].sum;
        end

        // Inactive stages are zeroed on every accept so that raising the
        // order later starts them from a clean state.
        mash_acc_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk    (aclk),
            .rst_n  (arst_n),
            .en     (accept),
            .clr    (!active),
            .cin    (dither_en && last && lfsr_reg[0]),
            .addend (addend),
            .sum    (sum),
            .cout   (carry)
        );

        assign carry_s = {{(OUT_BW-1){1'b0}}, carry && active};

        // Stage k+1's output is differentiated once before joining stage k;
        // hist_reg holds stage k's previous output for the stage below it.
        if (gi > 0) begin : g_hist
            logic signed [OUT_BW-1:0] hist_reg;
            always_ff @(posedge aclk or negedge arst_n) begin
                if (!arst_n) begin
                    hist_reg <= '0;
                end else if (accept) begin
                    hist_reg <= t_val;
                end
            end
        end

        if (gi == N_STAGES - 1) begin : g_diff_top
            assign diff = '0;
        end else begin : g_diff_mid
            assign diff = g_stage[gi+1].t_val - g_stage[gi+1].g_hist.hist_reg;
        end

        // The last active stage ignores the (possibly stale) history above it.
        always_comb begin
            t_val = '0;
            if (active) begin
                t_val = last ? carry_s : (carry_s + diff);
            end
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            lfsr_reg <= MASH_LFSR_SEED;
        end else if (accept) begin
            lfsr_reg <= mash_lfsr_next(lfsr_reg);
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            m_tdata_reg  <= '0;
            m_tvalid_reg <= 1'b0;
        end else if (accept) begin
            m_tdata_reg  <= g_stage[0].t_val;
            m_tvalid_reg <= 1'b1;
        end else if (m_axis_data_tready) begin
            m_tvalid_reg <= 1'b0;
        end
    end

endmodule
